multiplier_datapath: RTL and testbench

- Register/arithmetic datapath for the sequential shift-add binary multiplier.
- Sits directly beside and downstream of the multiplier FSM controller. It consumes load_reg/add_reg/shift_reg/dec_p and returns Q0/zero to the controller.
- Holds multiplicand B, accumulator A with carry C, multiplier Q and the iteration counter P.
- Presents the 2*bit product and a one-cycle done pulse.

---
 rtl/multiplier_datapath_pkg.sv | 17 +
 rtl/multiplier_datapath_p.sv | 30 +++
 rtl/multiplier_datapath.sv | 72 +++++++
 tb/tb_multiplier_datapath.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/multiplier_datapath_pkg.sv
// Shared constants and helpers for the shift-add multiplier datapath.
package multiplier_datapath_pkg;

    localparam int DEFAULT_BITS = 5;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/multiplier_datapath_p.sv
// Iteration counter P: loads BITS, counts down to zero and sticks there.
module mult_p_counter
    import multiplier_datapath_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS,
    parameter int PW   = clog2(BITS + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic          dec,
    output logic [PW-1:0] count,
    output logic          zero
);

    localparam logic [PW-1:0] LOAD_VALUE = PW'(BITS);

    assign zero = (count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VALUE;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/multiplier_datapath.sv
// Register datapath for the shift-add multiplier: B, {C,A,Q} and counter P.
module multiplier_datapath
    import multiplier_datapath_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [BITS-1:0]   multiplicand,
    input  logic [BITS-1:0]   multiplier,
    input  logic              load_reg,
    input  logic              add_reg,
    input  logic              shift_reg,
    input  logic              dec_p,
    output logic              Q0,
    output logic              zero,
    output logic [2*BITS-1:0] product,
    output logic              done
);

    localparam int PW = clog2(BITS + 1);

    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [BITS-1:0] q;
    logic            c;
    logic [PW-1:0]   p_count;
    logic [BITS:0]   sum;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign Q0      = q[0];
    assign product = {a, q};

    mult_p_counter #(
        .BITS(BITS),
        .PW  (PW)
    ) u_p_counter (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (load_reg),
        .dec    (dec_p),
        .count  (p_count),
        .zero   (zero)
    );

    // Shift outranks add; load outranks both.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a    <= '0;
            b    <= '0;
            q    <= '0;
            c    <= 1'b0;
            done <= 1'b0;
        end else if (load_reg) begin
            a    <= '0;
            b    <= multiplicand;
            q    <= multiplier;
            c    <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= shift_reg & zero;
            if (shift_reg) begin
                c <= 1'b0;
                a <= {c, a[BITS-1:1]};
                q <= {a[0], q[BITS-1:1]};
            end else if (add_reg) begin
                {c, a} <= sum;
            end
        end
    end

endmodule

// File: tb/tb_multiplier_datapath.sv
// Directed self-checking bench for multiplier_datapath with a product scoreboard.
module tb_multiplier_datapath;

    localparam int BITS = 5;

    logic              clk;
    logic              reset_n;
    logic [BITS-1:0]   multiplicand;
    logic [BITS-1:0]   multiplier;
    logic              load_reg;
    logic              add_reg;
    logic              shift_reg;
    logic              dec_p;
    logic              Q0;
    logic              zero;
    logic [2*BITS-1:0] product;
    logic              done;

    int checks = 0;
    int errors = 0;
    logic [2*BITS-1:0] sb_q[$];

    multiplier_datapath #(.BITS(BITS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .load_reg    (load_reg),
        .add_reg     (add_reg),
        .shift_reg   (shift_reg),
        .dec_p       (dec_p),
        .Q0          (Q0),
        .zero        (zero),
        .product     (product),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctrl();
        load_reg  = 1'b0;
        add_reg   = 1'b0;
        shift_reg = 1'b0;
        dec_p     = 1'b0;
    endtask

    task automatic do_load(input logic [BITS-1:0] mc, input logic [BITS-1:0] mp);
        multiplicand = mc;
        multiplier   = mp;
        load_reg     = 1'b1;
        step();
        idle_ctrl();
        sb_q.push_back((2*BITS)'(mc) * (2*BITS)'(mp));
    endtask

    task automatic iterate(input logic [BITS-1:0] mp, input int first, input int count, input string tag);
        for (int i = first; i < first + count; i++) begin
            chk({tag, "_q0"}, 32'(Q0), 32'(mp[i]));
            add_reg = Q0;
            dec_p   = 1'b1;
            step();
            idle_ctrl();
            chk({tag, "_zero_add"}, 32'(zero), 32'(i == BITS - 1));
            shift_reg = 1'b1;
            step();
            idle_ctrl();
            if (i != BITS - 1) chk({tag, "_done_early"}, 32'(done), 32'd0);
        end
    endtask

    task automatic multiply(input logic [BITS-1:0] mc, input logic [BITS-1:0] mp, input string tag);
        logic [2*BITS-1:0] exp;
        do_load(mc, mp);
        chk({tag, "_p_load"}, 32'(dut.p_count), 32'(BITS));
        iterate(mp, 0, BITS, tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_zero_end"}, 32'(zero), 32'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb_q.pop_front();
            chk({tag, "_product"}, 32'(product), 32'(exp));
        end
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, 32'(product), 32'((2*BITS)'(mc) * (2*BITS)'(mp)));
    endtask

    initial begin
        idle_ctrl();
        multiplicand = '0;
        multiplier   = '0;
        reset_n      = 1'b0;
        #12;
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_q0", 32'(Q0), 32'd0);
        reset_n = 1'b1;
        step();

        multiply(5'd13, 5'd11, "m13x11");
        chk("m13x11_val", 32'(product), 32'h08F);
        multiply(5'd31, 5'd31, "m31x31");
        chk("m31x31_val", 32'(product), 32'h3C1);
        multiply(5'd0, 5'd27, "m0x27");
        multiply(5'd27, 5'd0, "m27x0");

        do_load(5'd25, 5'd19);
        iterate(5'd19, 0, 2, "abort");
        #3;
        reset_n = 1'b0;
        #1;
        chk("abort_product", 32'(product), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_zero", 32'(zero), 32'd1);
        chk("abort_q0", 32'(Q0), 32'd0);
        void'(sb_q.pop_back());
        step();
        reset_n = 1'b1;
        step();
        multiply(5'd6, 5'd7, "m6x7");
        chk("m6x7_val", 32'(product), 32'd42);

        do_load(5'd3, 5'd9);
        void'(sb_q.pop_back());
        dec_p = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("dec_p_val", 32'(dut.p_count), (i < 4) ? 32'(4 - i) : 32'd0);
            chk("dec_zero", 32'(zero), 32'(i >= 4));
        end
        idle_ctrl();

        add_reg = 1'b1;
        step();
        idle_ctrl();
        multiplicand = 5'd9;
        multiplier   = 5'd22;
        load_reg     = 1'b1;
        add_reg      = 1'b1;
        shift_reg    = 1'b1;
        dec_p        = 1'b1;
        step();
        idle_ctrl();
        chk("lw_product", 32'(product), 32'd22);
        chk("lw_c", 32'(dut.c), 32'd0);
        chk("lw_p", 32'(dut.p_count), 32'd5);
        chk("lw_done", 32'(done), 32'd0);
        chk("lw_zero", 32'(zero), 32'd0);
        step();
        chk("idle_hold", 32'(product), 32'd22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
